// File: rtl/laser_pkg.sv
// Shared definitions for the dual-lane laser frame transmitter:
// the FSM state set and the fixed frame framing constants.
package laser_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        GAP
    } laser_state_e;

    localparam logic START_BIT = 1'b1;
    localparam logic STOP_BIT  = 1'b0;
    localparam int   DATA_BITS = 8;

endpackage

// File: rtl/laser_pair_fifo.sv
// Byte-pair buffer between the host push interface and the frame FSM.
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module laser_pair_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    // Full is judged before any same-cycle pop, so a push offered while full is dropped.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/laser_frame_tx.sv
// Dual-lane laser frame transmitter: pops byte pairs from a small FIFO and
// sends them bit-aligned as start / 8 data (MSB first) / stop / gap frames.
module laser_frame_tx
    import laser_pkg::*;
#(
    parameter int BIT_TICKS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_BITS   = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       en,
    input  logic [7:0] data_in1,
    input  logic [7:0] data_in2,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [1:0] laser1_out,
    output logic [1:0] laser2_out,
    output logic       busy,
    output logic       done
);

    localparam int TW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);
    localparam int CNT_MAX = (GAP_BITS > DATA_BITS) ? GAP_BITS : DATA_BITS;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    laser_state_e  state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    sh1_q, sh1_d;
    logic [7:0]    sh2_q, sh2_d;
    logic          bit1_q, bit1_d;
    logic          bit2_q, bit2_d;
    logic          busy_q;
    logic          done_q, done_d;
    logic          bit_end;
    logic          try_launch;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [15:0]   fifo_rdata;

    laser_pair_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk_i   (clock),
        .rst_ni  (reset),
        .push_i  (in_valid),
        .pop_i   (pop),
        .wdata_i ({data_in1, data_in2}),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        cnt_d      = cnt_q;
        sh1_d      = sh1_q;
        sh2_d      = sh2_q;
        bit1_d     = bit1_q;
        bit2_d     = bit2_q;
        pop        = 1'b0;
        try_launch = 1'b0;
        bit_end    = (tick_q == TICK_LAST);

        if (state_q != IDLE) tick_d = bit_end ? '0 : tick_q + 1'b1;

        case (state_q)
            IDLE: try_launch = 1'b1;
            START: if (bit_end) begin
                state_d = DATA;
                cnt_d   = '0;
                bit1_d  = sh1_q[7];
                bit2_d  = sh2_q[7];
            end
            DATA: if (bit_end) begin
                if (cnt_q == DATA_LAST) begin
                    state_d = STOP;
                    bit1_d  = STOP_BIT;
                    bit2_d  = STOP_BIT;
                end else begin
                    cnt_d  = cnt_q + 1'b1;
                    sh1_d  = {sh1_q[6:0], 1'b0};
                    sh2_d  = {sh2_q[6:0], 1'b0};
                    bit1_d = sh1_q[6];
                    bit2_d = sh2_q[6];
                end
            end
            STOP: if (bit_end) begin
                bit1_d = 1'b0;
                bit2_d = 1'b0;
                if (GAP_BITS == 0) begin
                    try_launch = 1'b1;
                end else begin
                    state_d = GAP;
                    cnt_d   = '0;
                end
            end
            GAP: if (bit_end) begin
                if (cnt_q == GAP_LAST) try_launch = 1'b1;
                else                   cnt_d = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Frame boundary: either chain straight into the next queued pair or park in IDLE.
        if (try_launch) begin
            if (en && !fifo_empty) begin
                pop     = 1'b1;
                state_d = START;
                tick_d  = '0;
                sh1_d   = fifo_rdata[15:8];
                sh2_d   = fifo_rdata[7:0];
                bit1_d  = START_BIT;
                bit2_d  = START_BIT;
            end else begin
                state_d = IDLE;
                tick_d  = '0;
                bit1_d  = 1'b0;
                bit2_d  = 1'b0;
            end
        end

        done_d = (state_d == STOP) && (tick_d == TICK_LAST);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            tick_q  <= '0;
            cnt_q   <= '0;
            sh1_q   <= '0;
            sh2_q   <= '0;
            bit1_q  <= 1'b0;
            bit2_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            cnt_q   <= cnt_d;
            sh1_q   <= sh1_d;
            sh2_q   <= sh2_d;
            bit1_q  <= bit1_d;
            bit2_q  <= bit2_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= done_d;
        end
    end

    assign in_ready   = !fifo_full;
    assign busy       = busy_q;
    assign done       = done_q;
    assign laser1_out = {bit1_q, busy_q};
    assign laser2_out = {bit2_q, busy_q};

endmodule

// File: tb/tb_laser_frame_tx.sv
// Self-checking bench for laser_frame_tx: directed scenarios plus random
// traffic, all compared every cycle against a timeline model of the frames.
module tb_laser_frame_tx;

    localparam int BT    = 8;
    localparam int DEPTH = 4;
    localparam int GAPB  = 2;
    localparam int FRAME = (10 + GAPB) * BT;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] data_in1 = 8'h00;
    logic [7:0] data_in2 = 8'h00;
    logic       in_ready;
    logic       busy;
    logic       done;
    logic [1:0] laser1_out;
    logic [1:0] laser2_out;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: pending pairs, the pair on air, and clocks since its start (-1 = idle).
    logic [15:0] q[$];
    logic [15:0] cur = 16'h0000;
    int          t = -1;

    logic [9:0] pat1;
    logic [9:0] pat2;

    always #5 clock = ~clock;

    laser_frame_tx #(
        .BIT_TICKS  (BT),
        .FIFO_DEPTH (DEPTH),
        .GAP_BITS   (GAPB)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .en         (en),
        .data_in1   (data_in1),
        .data_in2   (data_in2),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .laser1_out (laser1_out),
        .laser2_out (laser2_out),
        .busy       (busy),
        .done       (done)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] byte_v);
        int b;
        if (t < 0) return 1'b0;
        b = t / BT;
        if (b == 0) return 1'b1;
        if (b <= 8) return byte_v[8-b];
        return 1'b0;
    endfunction

    task automatic check_model();
        logic bz;
        bz = (t >= 0);
        chk("lane1", {6'd0, laser1_out}, {6'd0, exp_bit(cur[15:8]), bz});
        chk("lane2", {6'd0, laser2_out}, {6'd0, exp_bit(cur[7:0]), bz});
        chk("busy", {7'd0, busy}, {7'd0, bz});
        chk("done", {7'd0, done}, {7'd0, (t == 10*BT - 1)});
        chk("in_ready", {7'd0, in_ready}, {7'd0, (q.size() < DEPTH)});
    endtask

    // One clock: drive inputs after the falling edge, advance the model at the
    // rising edge, then compare on the next falling edge.
    task automatic cycle(input logic v, input logic [7:0] a, input logic [7:0] b);
        logic can_push;
        in_valid = v;
        data_in1 = a;
        data_in2 = b;
        @(posedge clock);
        if (reset) begin
            can_push = v && (q.size() < DEPTH);
            if (t < 0 || t == FRAME - 1) begin
                if (en && q.size() > 0) begin
                    cur = q.pop_front();
                    t = 0;
                end else begin
                    t = -1;
                end
            end else begin
                t++;
            end
            if (can_push) q.push_back({a, b});
        end
        @(negedge clock);
        check_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 8'h00);
    endtask

    initial begin
        pat1 = 10'b1101001010;
        pat2 = 10'b1001111000;

        // Reset state
        #1;
        chk("rst_lane1", {6'd0, laser1_out}, 8'h00);
        chk("rst_lane2", {6'd0, laser2_out}, 8'h00);
        chk("rst_busy", {7'd0, busy}, 8'h00);
        chk("rst_done", {7'd0, done}, 8'h00);
        chk("rst_in_ready", {7'd0, in_ready}, 8'h01);
        @(negedge clock);
        reset = 1'b1;
        idle(3);

        // Single pair A5 / 3C
        en = 1'b1;
        cycle(1'b1, 8'hA5, 8'h3C);
        for (int k = 0; k < 100; k++) begin
            idle(1);
            if (k % BT == BT/2 && k < 10*BT) begin
                chk("s1_lane1_bit", {7'd0, laser1_out[1]}, {7'd0, pat1[9 - k/BT]});
                chk("s1_lane2_bit", {7'd0, laser2_out[1]}, {7'd0, pat2[9 - k/BT]});
            end
            chk("s1_done", {7'd0, done}, {7'd0, (k == 79)});
            chk("s1_busy", {7'd0, busy}, {7'd0, (k < 96)});
        end

        // Back-to-back: fill with en low, drop a 5th, then stream four frames
        en = 1'b0;
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'($urandom), 8'($urandom));
        chk("s34_full", {7'd0, in_ready}, 8'h00);
        cycle(1'b1, 8'hFF, 8'hFF);
        chk("s34_still_full", {7'd0, in_ready}, 8'h00);
        en = 1'b1;
        idle(4*FRAME + 20);

        // en low: queued pairs stay put for 200 clocks, then start on the next edge
        en = 1'b0;
        cycle(1'b1, 8'h81, 8'h7E);
        cycle(1'b1, 8'h5A, 8'hC3);
        idle(200);
        chk("s35_quiet", {7'd0, busy}, 8'h00);
        en = 1'b1;
        idle(1);
        chk("s35_start", {6'd0, laser1_out}, 8'h03);
        idle(2*FRAME + 10);

        // en drop mid-frame: frame 1 finishes, frame 2 remains queued
        cycle(1'b1, 8'h96, 8'h69);
        cycle(1'b1, 8'h0F, 8'hF0);
        idle(4*BT - 2);
        en = 1'b0;
        idle(150);
        chk("s36_idle", {7'd0, busy}, 8'h00);
        en = 1'b1;
        idle(1);
        chk("s36_resume", {7'd0, busy}, 8'h01);
        idle(FRAME + 5);

        // Reset mid-frame at bit 5
        cycle(1'b1, 8'hE7, 8'h18);
        cycle(1'b1, 8'h33, 8'hCC);
        idle(5*BT + 2);
        reset = 1'b0;
        q.delete();
        t = -1;
        #1;
        chk("s37_lane1", {6'd0, laser1_out}, 8'h00);
        chk("s37_lane2", {6'd0, laser2_out}, 8'h00);
        chk("s37_busy", {7'd0, busy}, 8'h00);
        chk("s37_in_ready", {7'd0, in_ready}, 8'h01);
        @(negedge clock);
        idle(2);
        reset = 1'b1;
        idle(20);
        chk("s37_empty", {7'd0, busy}, 8'h00);

        // Boundary: push with DEPTH-1 queued and a pop on the same edge
        en = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) cycle(1'b1, 8'(8'h10 + i), 8'(8'h20 + i));
        en = 1'b1;
        cycle(1'b1, 8'h44, 8'h55);
        chk("s38_accept", {7'd0, in_ready}, 8'h01);
        cycle(1'b1, 8'h66, 8'h77);
        chk("s38_count", {7'd0, in_ready}, 8'h00);
        idle(5*FRAME + 20);

        // Random traffic with occasional en dropouts
        for (int i = 0; i < 1500; i++) begin
            en = ($urandom_range(0, 9) != 0);
            cycle($urandom_range(0, 3) == 0, 8'($urandom), 8'($urandom));
        end
        en = 1'b1;
        idle(6*FRAME);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/laser_frame_tx.md
LASER_FRAME_TX -- requirements
Module: laser_frame_tx

Interface
REQ-001 Parameter BIT_TICKS, default 8: clocks per transmitted bit; matches the receiver's 8-clock bit period.
REQ-002 Parameter FIFO_DEPTH, default 4: byte-pair entries buffered; power of two, at least 2.
REQ-003 Parameter GAP_BITS, default 2: idle bit periods forced between consecutive frames.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clock  input  1  system clock; all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 en  input  1  transmit enable; gates the start of new frames only.
REQ-008 data_in1  input  8  byte for lane 1.
REQ-009 data_in2  input  8  byte for lane 2.
REQ-010 in_valid  input  1  byte pair offered.
REQ-011 in_ready  output  1  FIFO not full; a push occurs when in_valid && in_ready.
REQ-012 laser1_out  output  2  [1] lane-1 modulated bit, [0] lane-1 bias enable.
REQ-013 laser2_out  output  2  [1] lane-2 modulated bit, [0] lane-2 bias enable.
REQ-014 busy  output  1  high in any state other than IDLE.
REQ-015 done  output  1  one-cycle pulse on the last clock of each STOP bit.

Function
REQ-016 Frame per lane SHALL be: start bit 1, data bits 7..0 MSB first, stop bit 0, then GAP_BITS bit periods of 0. The idle line SHALL be 0.
REQ-017 Both lanes SHALL be bit-aligned: the same bit index with the same tick count. The two lanes SHALL differ only in data.
REQ-018 Each bit SHALL be held for exactly BIT_TICKS clocks. A tick counter runs 0..BIT_TICKS-1 and wraps to 0 at the end of each bit.
REQ-019 FSM states SHALL be IDLE, START, DATA, STOP, GAP. Transitions:
- IDLE->START when en && FIFO non-empty; the FIFO head pops in the same cycle.
- START->DATA after 1 bit period.
- DATA->STOP after 8 bit periods.
- STOP->GAP after 1 bit period.
- GAP->START after GAP_BITS periods if en && non-empty (pop in the same cycle); otherwise GAP->IDLE.
REQ-020 If GAP_BITS=0, STOP SHALL go directly to START or IDLE under the same condition as GAP.
REQ-021 laser*_out[1] SHALL be registered and reflect the current state and bit. laser*_out[0] SHALL equal busy.
REQ-022 Latency: a push at edge N into an empty FIFO, with the FSM in IDLE and en high, pops at edge N+1. The start bit is driven from edge N+1 for BIT_TICKS clocks.
REQ-023 Frame period SHALL be (10+GAP_BITS)*BIT_TICKS clocks, i.e. 96 at defaults.
REQ-024 in_ready SHALL be !full, computed before any same-cycle pop. A push offered while full SHALL be dropped with no state change.
REQ-025 A simultaneous push and pop when not full SHALL leave the FIFO count unchanged.
REQ-026 Deasserting en mid-frame SHALL NOT truncate the frame. The current frame and its gap complete, then the FSM goes to IDLE.
REQ-027 Data popped into the shift registers SHALL be unaffected by later pushes.
REQ-028 FIFO pointers SHALL wrap modulo FIFO_DEPTH. The count SHALL range 0..FIFO_DEPTH.

Reset
REQ-029 Asserting reset SHALL immediately force all of the following, and discard FIFO contents:
- state IDLE, counters 0, FIFO empty;
- laser1_out=laser2_out=2'b00;
- busy=0, done=0, in_ready=1.
REQ-030 Reset mid-frame SHALL abort the frame with no further laser pulses. Operation SHALL resume from IDLE on the first edge after release.

Structure
REQ-031 The state enum (IDLE, START, DATA, STOP, GAP) and the frame constants (START_BIT=1, STOP_BIT=0, DATA_BITS=8) SHALL live in shared package laser_pkg.
REQ-032 The buffer SHALL be a separate sub-module laser_pair_fifo: 16-bit wide, FIFO_DEPTH deep, with full/empty flags and an async active-low reset.

Verification
REQ-033 Single pair: push 8'hA5 on lane 1 and 8'h3C on lane 2, with en=1.
- Lane 1 SHALL show 1,1,0,1,0,0,1,0,1,0; lane 2 SHALL show 1,0,0,1,1,1,1,0,0,0; each bit held 8 clocks.
- done SHALL pulse at clock 80 after the pop; busy SHALL fall at clock 96.
REQ-034 Back-to-back: push 4 pairs.
- in_ready SHALL be low after the 4th push until the first pop.
- A 5th push while full SHALL be dropped.
- Four frames SHALL be sent at a 96-clock pitch, with gaps of exactly 16 zero clocks.
REQ-035 en low: push 2 pairs with en=0. No output for 200 clocks. Raising en SHALL start transmission on the next edge.
REQ-036 en drop mid-frame: deassert en at bit 4 of frame 1 with frame 2 queued. Frame 1 SHALL complete, then IDLE; frame 2 SHALL stay queued.
REQ-037 Reset mid-frame: assert reset at bit 5. Outputs SHALL be 0 immediately, and an empty FIFO SHALL be observed after release.
REQ-038 Boundary: push while the FIFO holds FIFO_DEPTH-1 entries, with a pop in the same cycle. The push SHALL be accepted and the count SHALL be unchanged.
